uart_time_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx_byte.sv | 82 ++++++++
 rtl/uart_time_tx.sv | 85 ++++++++
 tb/tb_uart_time_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART time transmitter: serializer state codes,
// ASCII constants, frame length and the frame character encoder.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  localparam int         FRAME_LEN = 7;
  localparam logic [2:0] LAST_CHAR = 3'(FRAME_LEN - 1);

  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_e;

  // Character idx of "HH:MM\r\n". Values 60..63 are encoded arithmetically.
  function automatic logic [7:0] frame_char(input logic [2:0] idx,
                                            input logic [5:0] h,
                                            input logic [5:0] m);
    logic [5:0] h_t, h_u, m_t, m_u;
    logic [7:0] c;
    h_t = h / 6'd10;
    h_u = h % 6'd10;
    m_t = m / 6'd10;
    m_u = m % 6'd10;
    case (idx)
      3'd0:    c = ASCII_ZERO + {2'b00, h_t};
      3'd1:    c = ASCII_ZERO + {2'b00, h_u};
      3'd2:    c = CHAR_COLON;
      3'd3:    c = ASCII_ZERO + {2'b00, m_t};
      3'd4:    c = ASCII_ZERO + {2'b00, m_u};
      3'd5:    c = CHAR_CR;
      default: c = CHAR_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer, LSB first. A start request during the final
// stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_MHz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             baud_wrap;
  logic             load;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // State register
  always_ff @(posedge clk_MHz) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: each phase lasts one bit time, DATA lasts eight
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = START;
      START:   if (baud_wrap) state_d = DATA;
      DATA:    if (baud_wrap && bit_cnt == 3'd7) state_d = STOP;
      default: if (baud_wrap) state_d = start ? START : IDLE;
    endcase
  end

  // Outputs: line level, handshake, and the load strobe for the datapath
  always_comb begin
    tx        = 1'b1;
    ready     = (state_q == IDLE);
    byte_done = (state_q == STOP) && baud_wrap;
    load      = start && ((state_q == IDLE) || ((state_q == STOP) && baud_wrap));
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  // Baud/bit counters and shift register; baud counter held at 0 in IDLE
  always_ff @(posedge clk_MHz) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (load) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= data;
    end else if (state_q == IDLE) begin
      baud_cnt <= '0;
    end else if (baud_wrap) begin
      baud_cnt <= '0;
      if (state_q == DATA) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {1'b0, shreg[7:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_time_tx.sv
// Sends the current time as "HH:MM\r\n" over UART. Hours and minutes are
// snapshotted when the request is accepted so the frame stays consistent.
module uart_time_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk_MHz,
  input  logic       rst,
  input  logic       send,
  input  logic [5:0] ora_in,
  input  logic [5:0] min_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  seq_state_e seq_q, seq_d;
  logic [2:0] char_idx;
  logic [5:0] ora_snap, min_snap;
  logic       byte_start, byte_done, byte_ready;
  logic [7:0] byte_data;
  logic       last_char;
  logic       accept;

  assign last_char = (char_idx == LAST_CHAR);
  assign accept    = (seq_q == SEQ_IDLE) && send && byte_ready;

  // The first character comes straight from the inputs because the snapshot
  // is captured on the same edge that loads it into the serializer.
  assign byte_data = (seq_q == SEQ_IDLE) ? frame_char(3'd0, ora_in, min_in)
                                         : frame_char(char_idx + 3'd1, ora_snap, min_snap);

  // Sequencer state register
  always_ff @(posedge clk_MHz) begin
    if (rst) seq_q <= SEQ_IDLE;
    else     seq_q <= seq_d;
  end

  // Sequencer next state: run until the last character's stop bit ends
  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      SEQ_IDLE: if (accept) seq_d = SEQ_RUN;
      default:  if (byte_done && last_char) seq_d = SEQ_IDLE;
    endcase
  end

  // Sequencer outputs: status flags and serializer start request
  always_comb begin
    busy       = (seq_q == SEQ_RUN);
    done       = (seq_q == SEQ_RUN) && byte_done && last_char;
    byte_start = (seq_q == SEQ_IDLE) ? accept : (byte_done && !last_char);
  end

  // Snapshot and character index
  always_ff @(posedge clk_MHz) begin
    if (rst) begin
      char_idx <= '0;
      ora_snap <= '0;
      min_snap <= '0;
    end else if (accept) begin
      char_idx <= '0;
      ora_snap <= ora_in;
      min_snap <= min_in;
    end else if (seq_q == SEQ_RUN && byte_done && !last_char) begin
      char_idx <= char_idx + 3'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk_MHz  (clk_MHz),
    .rst      (rst),
    .start    (byte_start),
    .data     (byte_data),
    .tx       (tx),
    .ready    (byte_ready),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_uart_time_tx.sv
// Directed bench for uart_time_tx with CLKS_PER_BIT = 16.
module tb_uart_time_tx;

  localparam int CPB = 16;

  logic       clk_MHz = 1'b0;
  logic       rst     = 1'b1;
  logic       send    = 1'b0;
  logic [5:0] ora_in  = '0;
  logic [5:0] min_in  = '0;
  logic       tx, busy, done;

  int errors = 0;
  int checks = 0;

  uart_time_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk_MHz(clk_MHz),
    .rst    (rst),
    .send   (send),
    .ora_in (ora_in),
    .min_in (min_in),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk_MHz = ~clk_MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where the first start-bit cycle is visible; ends
  // at the negedge of the done cycle (cycle 70*CPB-1).
  task automatic recv_frame(input logic [55:0] exp, input string tag, input bit poke);
    logic [7:0] byte_val;
    logic       first;
    logic       last_done;
    int glitch = 0, bad_done = 0, frame_err = 0, busy_err = 0;
    last_done = 1'b0;
    first     = 1'b0;
    for (int c = 0; c < 7; c++) begin
      byte_val = '0;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          if (!(c == 0 && b == 0 && k == 0)) @(negedge clk_MHz);
          if (poke && c == 2 && b == 3) begin
            if (k == 0) send = 1'b1;
            else if (k == 1) send = 1'b0;
          end
          if (k == 0) first = tx;
          else if (tx !== first) glitch++;
          if (busy !== 1'b1) busy_err++;
          if (c == 6 && b == 9 && k == CPB - 1) last_done = done;
          else if (done !== 1'b0) bad_done++;
          if (k == 0) begin
            if (b == 0 && tx !== 1'b0) frame_err++;
            if (b == 9 && tx !== 1'b1) frame_err++;
            if (b >= 1 && b <= 8) byte_val[b-1] = tx;
          end
        end
      end
      check($sformatf("%s char%0d", tag, c), {24'd0, byte_val}, {24'd0, exp[55-8*c -: 8]});
    end
    check({tag, " glitches"}, glitch, 0);
    check({tag, " start/stop levels"}, frame_err, 0);
    check({tag, " busy drop"}, busy_err, 0);
    check({tag, " stray done"}, bad_done, 0);
    check({tag, " done at 1120"}, {31'd0, last_done}, 1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk_MHz);
      n++;
    end
    check({tag, " start seen"}, {31'd0, tx}, 0);
  endtask

  task automatic idle_window(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_MHz);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check({tag, " idle"}, bad, 0);
  endtask

  task automatic start_frame(input logic [5:0] h, input logic [5:0] m, input string tag);
    ora_in = h;
    min_in = m;
    send   = 1'b1;
    @(negedge clk_MHz);
    send = 1'b0;
    check({tag, " busy latency"}, {31'd0, busy}, 1);
    wait_start(tag);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk_MHz);
    check("reset tx", {31'd0, tx}, 1);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    rst = 1'b0;
    idle_window("post reset", 5);

    // Normal frame 13:07
    start_frame(6'd13, 6'd7, "t1307");
    recv_frame(56'h31_33_3A_30_37_0D_0A, "t1307", 1'b0);
    @(negedge clk_MHz);
    check("t1307 tx after", {31'd0, tx}, 1);
    check("t1307 busy after", {31'd0, busy}, 0);
    idle_window("t1307", 10);

    // Midnight and maximum
    start_frame(6'd0, 6'd0, "t0000");
    recv_frame(56'h30_30_3A_30_30_0D_0A, "t0000", 1'b0);
    idle_window("t0000", 3);
    start_frame(6'd23, 6'd59, "t2359");
    recv_frame(56'h32_33_3A_35_39_0D_0A, "t2359", 1'b0);
    idle_window("t2359", 3);

    // Out-of-range values are encoded, not clamped
    start_frame(6'd63, 6'd60, "t6360");
    recv_frame(56'h36_33_3A_36_30_0D_0A, "t6360", 1'b0);
    idle_window("t6360", 3);

    // Snapshot and ignore-while-busy
    start_frame(6'd12, 6'd30, "snap");
    ora_in = 6'd5;
    min_in = 6'd5;
    recv_frame(56'h31_32_3A_33_30_0D_0A, "snap", 1'b1);
    idle_window("snap no requeue", 200);

    // Reset in the middle of character 2's data bits
    start_frame(6'd9, 6'd41, "abort");
    repeat (2 * 10 * CPB + CPB + 40) @(negedge clk_MHz);
    rst = 1'b1;
    @(negedge clk_MHz);
    check("abort tx", {31'd0, tx}, 1);
    check("abort busy", {31'd0, busy}, 0);
    check("abort done", {31'd0, done}, 0);
    rst = 1'b0;
    idle_window("abort", 5);
    start_frame(6'd7, 6'd44, "after abort");
    recv_frame(56'h30_37_3A_34_34_0D_0A, "after abort", 1'b0);
    idle_window("after abort", 3);

    // Continuous send: back-to-back frames with one idle cycle
    ora_in = 6'd8;
    min_in = 6'd15;
    send   = 1'b1;
    @(negedge clk_MHz);
    check("cont busy latency", {31'd0, busy}, 1);
    wait_start("cont1");
    recv_frame(56'h30_38_3A_31_35_0D_0A, "cont1", 1'b0);
    @(negedge clk_MHz);
    check("cont gap tx", {31'd0, tx}, 1);
    check("cont gap busy", {31'd0, busy}, 0);
    @(negedge clk_MHz);
    check("cont restart tx", {31'd0, tx}, 0);
    check("cont restart busy", {31'd0, busy}, 1);
    send = 1'b0;
    recv_frame(56'h30_38_3A_31_35_0D_0A, "cont2", 1'b0);
    idle_window("cont end", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
